// File: rtl/sprite_row_fetcher.sv
// sprite_row_fetcher
//   Reader side of the sprite ROM. A (tile code, row) request is turned into
//   a ROM address; the returned row is latched and streamed out one pixel per
//   clock, column 0 first. Column 0 is the row MSB unless the optional
//   horizontal mirror is enabled and requested.
//
//   Optional feature macro: SPRITE_MIRROR_EN
//     defined   -> mirror is captured with each request; a mirrored request
//                  streams LSB first (column 0 = bit 0).
//     undefined -> mirror port is present but ignored; always MSB first.
//
//   FSM: IDLE -> FETCH (1 cycle) -> SHIFT (DATA_WIDTH cycles) -> DONE (1) -> IDLE.
//   All outputs come straight from registers.

module sprite_row_fetcher #(
  parameter  int CODE_WIDTH = 2,
  parameter  int ROW_WIDTH  = 5,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 7,
  localparam int COL_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [CODE_WIDTH-1:0] tile_code,
  input  logic [ROW_WIDTH-1:0]  row,
  input  logic                  mirror,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output logic                  pixel_valid,
  output logic                  pixel,
  output logic [COL_WIDTH-1:0]  col,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [CODE_WIDTH-1:0] r_code;
  logic [ROW_WIDTH-1:0]  r_row;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [COL_WIDTH-1:0]  r_col;
  logic                  r_busy;
  logic                  r_pixel_valid;
  logic                  r_pixel;
  logic                  r_done;

  // Request is accepted only from IDLE; Reset has priority over start.
  logic                  w_accept;
  assign w_accept = (r_state == S_IDLE) && start;

  // Effective scan direction of the request currently in flight.
  logic                  w_mirror_q;

`ifdef SPRITE_MIRROR_EN
  logic                  r_mirror;

  // Capture the flip request together with the code/row of an accepted start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_mirror <= 1'b0;
    end else if (w_accept) begin
      r_mirror <= mirror;
    end
  end

  assign w_mirror_q = r_mirror;
`else
  // Mirror is not supported in this build; the port is kept for pin compatibility.
  logic                  w_unused_mirror;
  assign w_unused_mirror = mirror;
  assign w_mirror_q      = 1'b0;
`endif

  // First pixel of a freshly loaded row, taken directly from the ROM data.
  logic                  w_load_pixel;
  assign w_load_pixel = w_mirror_q ? rom_data[0] : rom_data[DATA_WIDTH-1];

  // Pixel that becomes current after the next shift, and the shifted row.
  logic                  w_next_pixel;
  logic [DATA_WIDTH-1:0] w_shift_next;
  assign w_next_pixel = w_mirror_q ? r_shift[1] : r_shift[DATA_WIDTH-2];
  assign w_shift_next = w_mirror_q ? (r_shift >> 1) : (r_shift << 1);

  // Main FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_code        <= '0;
      r_row         <= '0;
      r_shift       <= '0;
      r_col         <= '0;
      r_busy        <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_pixel       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // ROM address follows code/row, so it only moves on an accepted start.
            r_code  <= tile_code;
            r_row   <= row;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          // ROM data for {code,row} is valid this cycle; latch it and present column 0.
          r_shift       <= rom_data;
          r_col         <= '0;
          r_pixel       <= w_load_pixel;
          r_pixel_valid <= 1'b1;
          r_state       <= S_SHIFT;
        end

        S_SHIFT: begin
          r_shift <= w_shift_next;
          if (r_col == LAST_COL) begin
            // Column counter stops at the last column; it is held through DONE.
            r_pixel_valid <= 1'b0;
            r_pixel       <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_col   <= r_col + 1'b1;
            r_pixel <= w_next_pixel;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_pixel_valid <= 1'b0;
          r_pixel       <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = {r_code, r_row};
  assign busy        = r_busy;
  assign pixel_valid = r_pixel_valid;
  assign pixel       = r_pixel;
  assign col         = r_col;
  assign done        = r_done;

endmodule
